// File: rtl/hex_page_scheduler_pkg.sv
// hex_page_scheduler_pkg
// Shared constants for the HEX page scheduler slice: FSM state encodings
// and the segment pattern for the digit "0".
// Ports: none (package).

package hex_page_scheduler_pkg;

  // Scheduler FSM states; 2'd3 is unused and recovers to ST_AUTO.
  localparam logic [1:0] ST_AUTO   = 2'd0;
  localparam logic [1:0] ST_MANUAL = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  // Active-low segments {g,f,e,d,c,b,a} showing "0".
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

endpackage

// File: rtl/hex_decoder.sv
// hex_decoder
// Shared 4-bit to 7-segment decoder for the DE1/DE2 HEX displays.
// Segments are active-low, bit order {g,f,e,d,c,b,a}.
// Ports:
//   hex_digit  in  4  nibble to display
//   segments   out 7  active-low segment drive

module hex_decoder
  import hex_page_scheduler_pkg::*;
(
  input  logic [3:0] hex_digit,
  output logic [6:0] segments
);

  always_comb begin
    segments = SEG_ZERO;
    case (hex_digit)
      4'h0: segments = SEG_ZERO;
      4'h1: segments = 7'b1111001;
      4'h2: segments = 7'b0100100;
      4'h3: segments = 7'b0110000;
      4'h4: segments = 7'b0011001;
      4'h5: segments = 7'b0010010;
      4'h6: segments = 7'b0000010;
      4'h7: segments = 7'b1111000;
      4'h8: segments = 7'b0000000;
      4'h9: segments = 7'b0010000;
      4'hA: segments = 7'b0001000;
      4'hB: segments = 7'b0000011;
      4'hC: segments = 7'b1000110;
      4'hD: segments = 7'b0100001;
      4'hE: segments = 7'b0000110;
      4'hF: segments = 7'b0001110;
      default: segments = SEG_ZERO;
    endcase
  end

endmodule

// File: rtl/hex_page_scheduler_step_sync.sv
// hex_page_scheduler_step_sync
// Brings the raw active-low push-button into the clock domain through two
// flops, then emits a single-cycle pulse on each press (falling edge).
// Ports:
//   clock       in  1  system clock
//   reset       in  1  asynchronous active-low reset
//   step_n      in  1  raw active-low button, asynchronous to clock
//   step_pulse  out 1  one-cycle pulse per press

module hex_page_scheduler_step_sync (
  input  logic clock,
  input  logic reset,
  input  logic step_n,
  output logic step_pulse
);

  logic s1, s2, s3;

  // All three flops reset to the idle (released) level, so coming out of
  // reset with the button up can never look like a press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= step_n;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // High only on the cycle where the synchronized level has just dropped.
  assign step_pulse = s3 & ~s2;

endmodule

// File: rtl/hex_page_scheduler.sv
// hex_page_scheduler
// Time-multiplexes NUM_PAGES 16-bit debug words onto four HEX data digits
// plus a page-index digit. Pages rotate after DWELL cycles in auto mode,
// step on each button press, and can be frozen on the current snapshot.
// Ports:
//   clock      in  1               system clock, rising edge
//   reset      in  1               asynchronous active-low reset
//   page_data  in  16*NUM_PAGES    packed pages, page p at [16p+15:16p]
//   auto_en    in  1               1 = auto-rotate, 0 = manual stepping
//   freeze     in  1               1 = hold displayed snapshot and page
//   step_n     in  1               raw active-low push-button
//   page_sel   out 4               index of the current page
//   hex3..hex0 out 7 each          segments for display nibbles [15:12]..[3:0]
//   hex_page   out 7               segments for page_sel

module hex_page_scheduler
  import hex_page_scheduler_pkg::*;
#(
  parameter int NUM_PAGES = 4,
  parameter int DWELL     = 50000000,
  parameter int DWELL_W   = 26
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [16*NUM_PAGES-1:0] page_data,
  input  logic                    auto_en,
  input  logic                    freeze,
  input  logic                    step_n,
  output logic [3:0]              page_sel,
  output logic [6:0]              hex3,
  output logic [6:0]              hex2,
  output logic [6:0]              hex1,
  output logic [6:0]              hex0,
  output logic [6:0]              hex_page
);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [3:0]         PAGE_LAST  = 4'(NUM_PAGES - 1);

  logic [1:0]         state;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [15:0]        display_q;
  logic [15:0]        page_word;
  logic [3:0]         next_page;
  logic               step_pulse;

  hex_page_scheduler_step_sync u_step_sync (
    .clock      (clock),
    .reset      (reset),
    .step_n     (step_n),
    .step_pulse (step_pulse)
  );

  // Explicit wrap so non-power-of-two page counts never reach an empty page.
  assign next_page = (page_sel == PAGE_LAST) ? 4'd0 : page_sel + 4'd1;

  // Select the current page word from the packed bus.
  always_comb begin
    page_word = 16'h0000;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (page_sel == 4'(p)) page_word = page_data[16*p +: 16];
    end
  end

  // Scheduler FSM. Freeze outranks mode changes, which outrank step/dwell;
  // a step seen while frozen or on the unfreeze edge is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_AUTO;
      page_sel  <= 4'd0;
      dwell_cnt <= '0;
    end else if (freeze) begin
      state <= ST_FROZEN;
    end else begin
      case (state)
        ST_FROZEN: begin
          state     <= auto_en ? ST_AUTO : ST_MANUAL;
          dwell_cnt <= '0;
        end
        ST_MANUAL: begin
          dwell_cnt <= '0;
          if (auto_en) begin
            state <= ST_AUTO;
          end else if (step_pulse) begin
            page_sel <= next_page;
          end
        end
        default: begin
          state <= ST_AUTO;
          if (!auto_en) begin
            state     <= ST_MANUAL;
            dwell_cnt <= '0;
          end else if (step_pulse || dwell_cnt == DWELL_LAST) begin
            page_sel  <= next_page;
            dwell_cnt <= '0;
          end else begin
            dwell_cnt <= dwell_cnt + DWELL_W'(1);
          end
        end
      endcase
    end
  end

  // Snapshot register: follows the selected page one cycle late and holds
  // whenever freeze is asserted, so page_data edits stay hidden until release.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      display_q <= 16'h0000;
    end else if (!freeze) begin
      display_q <= page_word;
    end
  end

  hex_decoder u_dec3 (.hex_digit(display_q[15:12]), .segments(hex3));
  hex_decoder u_dec2 (.hex_digit(display_q[11:8]),  .segments(hex2));
  hex_decoder u_dec1 (.hex_digit(display_q[7:4]),   .segments(hex1));
  hex_decoder u_dec0 (.hex_digit(display_q[3:0]),   .segments(hex0));
  hex_decoder u_decp (.hex_digit(page_sel),         .segments(hex_page));

endmodule

// File: tb/tb_hex_page_scheduler.sv
// tb_hex_page_scheduler
// Directed bench for hex_page_scheduler. DUT a: NUM_PAGES=4, DWELL=4.
// DUT b: NUM_PAGES=3, DWELL=4, used for the non-power-of-two wrap.

module tb_hex_page_scheduler;

  logic        clock;
  logic        reset;
  logic [63:0] page_data_a;
  logic        auto_en_a, freeze_a, step_n_a;
  logic [3:0]  page_sel_a;
  logic [6:0]  hex3_a, hex2_a, hex1_a, hex0_a, hex_page_a;

  logic [47:0] page_data_b;
  logic        auto_en_b, freeze_b, step_n_b;
  logic [3:0]  page_sel_b;
  logic [6:0]  hex3_b, hex2_b, hex1_b, hex0_b, hex_page_b;

  int checks = 0;
  int errors = 0;

  hex_page_scheduler #(.NUM_PAGES(4), .DWELL(4), .DWELL_W(3)) dut_a (
    .clock(clock), .reset(reset), .page_data(page_data_a),
    .auto_en(auto_en_a), .freeze(freeze_a), .step_n(step_n_a),
    .page_sel(page_sel_a), .hex3(hex3_a), .hex2(hex2_a),
    .hex1(hex1_a), .hex0(hex0_a), .hex_page(hex_page_a)
  );

  hex_page_scheduler #(.NUM_PAGES(3), .DWELL(4), .DWELL_W(3)) dut_b (
    .clock(clock), .reset(reset), .page_data(page_data_b),
    .auto_en(auto_en_b), .freeze(freeze_b), .step_n(step_n_b),
    .page_sel(page_sel_b), .hex3(hex3_b), .hex2(hex2_b),
    .hex1(hex1_b), .hex0(hex0_b), .hex_page(hex_page_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference active-low segment patterns {g,f,e,d,c,b,a}.
  function automatic logic [6:0] segOf(input logic [3:0] n);
    case (n)
      4'h0: segOf = 7'b1000000;  4'h1: segOf = 7'b1111001;
      4'h2: segOf = 7'b0100100;  4'h3: segOf = 7'b0110000;
      4'h4: segOf = 7'b0011001;  4'h5: segOf = 7'b0010010;
      4'h6: segOf = 7'b0000010;  4'h7: segOf = 7'b1111000;
      4'h8: segOf = 7'b0000000;  4'h9: segOf = 7'b0010000;
      4'hA: segOf = 7'b0001000;  4'hB: segOf = 7'b0000011;
      4'hC: segOf = 7'b1000110;  4'hD: segOf = 7'b0100001;
      4'hE: segOf = 7'b0000110;  default: segOf = 7'b0001110;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkDisplayA(input string tag, input logic [15:0] word,
                               input logic [3:0] page);
    checkOutput({tag, ".page_sel"}, {12'h0, page_sel_a}, {12'h0, page});
    checkOutput({tag, ".hex3"}, {9'h0, hex3_a}, {9'h0, segOf(word[15:12])});
    checkOutput({tag, ".hex2"}, {9'h0, hex2_a}, {9'h0, segOf(word[11:8])});
    checkOutput({tag, ".hex1"}, {9'h0, hex1_a}, {9'h0, segOf(word[7:4])});
    checkOutput({tag, ".hex0"}, {9'h0, hex0_a}, {9'h0, segOf(word[3:0])});
    checkOutput({tag, ".hex_page"}, {9'h0, hex_page_a}, {9'h0, segOf(page)});
  endtask

  task automatic checkPageA(input string tag, input logic [3:0] page);
    checkOutput(tag, {12'h0, page_sel_a}, {12'h0, page});
  endtask

  task automatic applyStimulus();
    logic [15:0] pages [4];
    pages[0] = 16'h1234; pages[1] = 16'hABCD; pages[2] = 16'h00FF; pages[3] = 16'hBEEF;

    reset = 1'b0;
    page_data_a = {pages[3], pages[2], pages[1], pages[0]};
    auto_en_a = 1'b1; freeze_a = 1'b0; step_n_a = 1'b1;
    page_data_b = {16'h3333, 16'h2222, 16'h1111};
    auto_en_b = 1'b0; freeze_b = 1'b0; step_n_b = 1'b1;
    tick(2);
    checkDisplayA("reset", 16'h0000, 4'd0);
    checkOutput("reset.b_page", {12'h0, page_sel_b}, 16'h0);
    reset = 1'b1;

    // Auto rotation: page changes on every 4th edge, display lags by one.
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick(1);
      checkDisplayA($sformatf("auto%0d", cyc), pages[((cyc - 1) / 4) % 4],
                    4'((cyc / 4) % 4));
    end

    // Step pulse lands on the dwell-expiry cycle: advance exactly once.
    tick(1);
    step_n_a = 1'b0;
    tick(2);
    checkPageA("coincide.before", 4'd0);
    tick(1);
    checkPageA("coincide.once", 4'd1);
    step_n_a = 1'b1;
    tick(3);
    checkPageA("coincide.hold", 4'd1);
    tick(1);
    checkPageA("coincide.next", 4'd2);

    // Rotate on to page 1 (ABCD), then freeze.
    tick(13);
    checkDisplayA("pre_freeze", 16'hABCD, 4'd1);
    freeze_a = 1'b1;
    tick(1);
    page_data_a[31:16] = 16'h5555;
    step_n_a = 1'b0;
    tick(4);
    step_n_a = 1'b1;
    tick(2);
    checkDisplayA("frozen", 16'hABCD, 4'd1);
    freeze_a = 1'b0;
    tick(1);
    checkDisplayA("unfreeze", 16'h5555, 4'd1);
    tick(3);
    checkPageA("unfreeze.hold", 4'd1);
    tick(1);
    checkPageA("unfreeze.adv", 4'd2);

    // Manual stepping with long presses: one advance per press.
    auto_en_a = 1'b0;
    tick(1);
    for (int press = 0; press < 2; press++) begin
      step_n_a = 1'b0;
      tick(2);
      checkPageA($sformatf("manual%0d.wait", press), 4'(2 + press));
      tick(1);
      checkPageA($sformatf("manual%0d.step", press), 4'((3 + press) % 4));
      tick(17);
      checkPageA($sformatf("manual%0d.held", press), 4'((3 + press) % 4));
      step_n_a = 1'b1;
      tick(3);
    end
    checkDisplayA("manual.wrap", 16'h1234, 4'd0);

    // Back to auto keeps page and restarts the dwell.
    auto_en_a = 1'b1;
    tick(4);
    checkPageA("reauto.hold", 4'd0);
    tick(1);
    checkPageA("reauto.adv", 4'd1);

    // Three-page wrap on dut_b.
    for (int press = 0; press < 4; press++) begin
      logic [3:0] exp_page;
      exp_page = 4'((press + 1) % 3);
      step_n_b = 1'b0;
      tick(3);
      checkOutput($sformatf("wrap3.%0d.page", press), {12'h0, page_sel_b}, {12'h0, exp_page});
      checkOutput($sformatf("wrap3.%0d.hex_page", press), {9'h0, hex_page_b},
                  {9'h0, segOf(exp_page)});
      step_n_b = 1'b1;
      tick(3);
    end

    // Asynchronous reset mid-rotation with the button held.
    tick(2);
    step_n_a = 1'b0;
    tick(1);
    reset = 1'b0;
    #1;
    checkDisplayA("midreset", 16'h0000, 4'd0);
    step_n_a = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(3);
    checkDisplayA("postreset", 16'h1234, 4'd0);
    tick(1);
    checkPageA("postreset.adv", 4'd1);
  endtask

  initial begin
    applyStimulus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/hex_page_scheduler.md
Name: hex_page_scheduler

Overview:
- Time-multiplexes NUM_PAGES 16-bit debug words (PC, IR, register values, etc.) onto four 7-segment data digits plus one page-index digit on the DE1/DE2 board.
- Pages advance automatically after a programmable dwell time, or one at a time from a push-button.
- A freeze input holds the current snapshot on the display.
- Sits between the processor's debug taps and the board HEX pins, and drives the existing 4-bit-to-7-segment decoder.

Parameters:
- NUM_PAGES, 4, number of 16-bit pages; legal range 2..16.
- DWELL, 50000000, clock cycles each page is shown in auto mode; legal range ≥ 2.
- DWELL_W, 26, width of the dwell counter; must satisfy 2^DWELL_W > DWELL-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- page_data  in  16*NUM_PAGES  packed pages; page p occupies bits [16p+15:16p].
- auto_en  in  1  1 = auto-rotate, 0 = manual stepping.
- freeze  in  1  1 = hold the displayed snapshot and page.
- step_n  in  1  raw push-button input, active-low, asynchronous to clock.
- page_sel  out  4  index of the current page.
- hex3  out  7  segments for nibble [15:12]; active-low segments, bit order per the team HEX decoder.
- hex2  out  7  segments for nibble [11:8].
- hex1  out  7  segments for nibble [7:4].
- hex0  out  7  segments for nibble [3:0].
- hex_page  out  7  segments for page_sel.

Behaviour:
- Reset (reset=0, asynchronous):
  - page_sel=0, dwell_cnt=0, state=AUTO.
  - Synchronizer flops = 1.
  - display_q=16'h0000, so hex0..hex3 and hex_page all show "0" (7'b1000000).
- display_q is a 16-bit register. When not FROZEN it loads page_data[page_sel] every cycle, giving one cycle of latency from page_sel/page_data to the hex outputs. The hex outputs are combinational decodes of display_q and page_sel.
- Step synchronizer:
  - step_n passes through two flops (s1, s2), then a history flop s3.
  - step_pulse = s3 & ~s2: one cycle per button press, regardless of how long the button is held.
  - If step_n falls before edge k, step_pulse is high during the cycle after edge k+1.
- States: AUTO, MANUAL, FROZEN. Priority: freeze > mode change > step/dwell.
- AUTO:
  - dwell_cnt increments each cycle.
  - When dwell_cnt==DWELL-1: dwell_cnt←0 and page_sel advances.
  - step_pulse also advances page_sel and clears dwell_cnt.
  - Dwell expiry and step_pulse in the same cycle: advance by exactly one.
  - auto_en=0 → MANUAL, dwell_cnt←0.
- MANUAL:
  - dwell_cnt is held at 0.
  - step_pulse advances page_sel.
  - auto_en=1 → AUTO, dwell_cnt←0, page_sel unchanged.
- FROZEN (entered from either state when freeze=1):
  - display_q, page_sel and dwell_cnt hold.
  - step_pulse is discarded; it is not queued.
  - freeze=0 → AUTO if auto_en else MANUAL, with dwell_cnt←0. display_q resumes loading on the next edge.
- Advance rule: page_sel←(page_sel==NUM_PAGES-1)?0:page_sel+1. Wrap applies for non-power-of-2 NUM_PAGES; page_sel never exceeds NUM_PAGES-1.
- Any change of page_data in FROZEN is not shown until unfreeze.
- Reset asserted mid-operation returns everything to the reset values immediately. No step pulse may be generated by the synchronizer release after reset.

Decomposition:
- Shared package:
  - State encoding constants ST_AUTO=2'd0, ST_MANUAL=2'd1, ST_FROZEN=2'd2.
  - SEG_ZERO=7'b1000000.
- Sub-module hex_step_sync: 2-flop synchronizer plus falling-edge detector producing step_pulse.
- The five digit decodes reuse the existing HEX decoder module, instantiated five times. No new decoder is written.

Test Plan (NUM_PAGES=4, DWELL=4; pages 0..3 = 16'h1234, 16'hABCD, 16'h00FF, 16'hBEEF):
1. Release reset with auto_en=1, freeze=0 → page_sel steps 0,1,2,3,0, changing every 4 clocks. hex3..hex0 show 1234, then ABCD one cycle after page_sel=1, and so on. hex_page tracks the index.
2. auto_en=0, step_n held low for 20 cycles and then released, repeated twice → page_sel 0→1→2 exactly. Each change occurs on the third rising edge after the fall.
3. In AUTO at dwell_cnt==3, a step_pulse coincides with expiry → page_sel advances by exactly 1 and dwell_cnt=0.
4. In AUTO showing ABCD, assert freeze, then change page 1 to 16'h5555 and press step → display stays ABCD and page_sel stays 1. Deassert freeze → 5555 is shown one cycle later, and the next advance comes 4 cycles after unfreeze.
5. NUM_PAGES=3, manual mode, 4 steps → page_sel 1,2,0,1; never 3.
6. Assert reset mid-rotation with step_n low → immediately all hex outputs = 7'b1000000 and page_sel=0. Release reset with step_n high → no spurious advance.
